// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants, types and helpers for the programmable
//               clock divider / phase generator.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int MIN_DIV    = 2;
    localparam int MAX_PHASES = 32;
    localparam int MAX_PH_W   = 5;

    // Widest phase index supported; callers cast down to their own PH_W.
    typedef logic [MAX_PH_W-1:0] phase_t;

    function automatic logic [31:0] clamp_div(input logic [31:0] x);
        return (x < 32'(MIN_DIV)) ? 32'(MIN_DIV) : x;
    endfunction

    function automatic logic [MAX_PHASES-1:0] onehot(input phase_t idx);
        return {{(MAX_PHASES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_phase_gen_phase_ring.sv
`default_nettype none
// ============================================================================
// Module      : phase_ring
// Description : Modulo-NUM_PHASES phase counter advanced by the divider wrap,
//               with a registered one-hot strobe for the new phase.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_ring
    import clk_div_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic [PH_W-1:0]       phase,
    output logic [NUM_PHASES-1:0] phase_strobe
);

    localparam logic [PH_W-1:0] c_last_phase = PH_W'(NUM_PHASES - 1);

    logic [PH_W-1:0]       r_phase;
    logic [PH_W-1:0]       w_phase_n;
    logic [NUM_PHASES-1:0] r_strobe;

    always_comb begin
        w_phase_n = (r_phase == c_last_phase) ? '0 : r_phase + PH_W'(1);
    end

    // Reset parks on the last phase so the first advance lands on phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= c_last_phase;
            r_strobe <= '0;
        end else if (advance) begin
            r_phase  <= w_phase_n;
            r_strobe <= NUM_PHASES'(onehot(phase_t'(w_phase_n)));
        end else begin
            r_strobe <= '0;
        end
    end

    assign phase        = r_phase;
    assign phase_strobe = r_strobe;

endmodule : phase_ring
`default_nettype wire

// File: rtl/clk_div_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_phase_gen
// Description : Programmable clock divider with runtime-loadable ratio applied
//               at period boundaries, period tick and rotating phase strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_phase_gen
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int NUM_PHASES  = 2,
    parameter int DEFAULT_DIV = 2,
    parameter int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CNT_W-1:0]      div_ratio,
    input  logic                  div_load,
    output logic                  out_clk,
    output logic                  tick,
    output logic [PH_W-1:0]       phase,
    output logic [NUM_PHASES-1:0] phase_strobe,
    output logic [CNT_W-1:0]      cur_div,
    output logic                  load_pending
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_load_pending;
    logic             r_out_clk;
    logic             r_tick;

    logic             w_wrap;
    logic             w_advance;
    logic [CNT_W-1:0] w_cnt_n;
    logic [CNT_W-1:0] w_cur_div_n;
    logic [CNT_W-1:0] w_high_cnt;

    // High-phase length is ceil(D/2), computed without widening the counter.
    always_comb begin
        w_wrap      = (r_cnt == r_cur_div - CNT_W'(1));
        w_cnt_n     = w_wrap ? '0 : r_cnt + CNT_W'(1);
        w_cur_div_n = w_wrap ? r_shadow : r_cur_div;
        w_high_cnt  = (w_cur_div_n >> 1) + {{(CNT_W-1){1'b0}}, w_cur_div_n[0]};
        w_advance   = en & w_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= c_default_div - CNT_W'(1);
            r_cur_div      <= c_default_div;
            r_shadow       <= c_default_div;
            r_load_pending <= 1'b0;
            r_out_clk      <= 1'b0;
            r_tick         <= 1'b0;
        end else begin
            if (en) begin
                r_cnt     <= w_cnt_n;
                r_cur_div <= w_cur_div_n;
                r_out_clk <= (w_cnt_n < w_high_cnt);
                r_tick    <= w_wrap;
            end else begin
                r_tick    <= 1'b0;
            end
            // A load coinciding with a wrap lands in the shadow for the next period.
            if (div_load) begin
                r_shadow       <= CNT_W'(clamp_div(32'(div_ratio)));
                r_load_pending <= 1'b1;
            end else if (w_advance) begin
                r_load_pending <= 1'b0;
            end
        end
    end

    phase_ring #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_phase_ring (
        .clk          (clk),
        .rst          (rst),
        .advance      (w_advance),
        .phase        (phase),
        .phase_strobe (phase_strobe)
    );

    assign out_clk      = r_out_clk;
    assign tick         = r_tick;
    assign cur_div      = r_cur_div;
    assign load_pending = r_load_pending;

endmodule : clk_div_phase_gen
`default_nettype wire

// File: tb/tb_clk_div_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_phase_gen
// Description : Directed self-checking bench for clk_div_phase_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_phase_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] div_ratio;
    logic       div_load;
    logic       out_clk;
    logic       tick;
    logic [0:0] phase;
    logic [1:0] phase_strobe;
    logic [7:0] cur_div;
    logic       load_pending;

    logic       en3;
    logic [7:0] div_ratio3;
    logic       div_load3;
    logic       out_clk3;
    logic       tick3;
    logic [1:0] phase3;
    logic [2:0] phase_strobe3;
    logic [7:0] cur_div3;
    logic       load_pending3;

    int n_total = 0;
    int n_bad   = 0;

    int e_out[4]   = '{1, 0, 1, 0};
    int e_tick[4]  = '{1, 0, 1, 0};
    int e_strb[4]  = '{1, 0, 2, 0};
    int e_out5[5]  = '{1, 1, 0, 0, 1};
    int e_tick5[5] = '{0, 0, 0, 0, 1};
    int e_oresm[4] = '{1, 0, 0, 1};
    int e_tresm[4] = '{0, 0, 0, 1};
    int e_str3[4]  = '{1, 2, 4, 1};

    always #5 clk = ~clk;

    clk_div_phase_gen #(
        .CNT_W       (8),
        .NUM_PHASES  (2),
        .DEFAULT_DIV (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div_ratio    (div_ratio),
        .div_load     (div_load),
        .out_clk      (out_clk),
        .tick         (tick),
        .phase        (phase),
        .phase_strobe (phase_strobe),
        .cur_div      (cur_div),
        .load_pending (load_pending)
    );

    clk_div_phase_gen #(
        .CNT_W       (8),
        .NUM_PHASES  (3),
        .DEFAULT_DIV (4)
    ) dut3 (
        .clk          (clk),
        .rst          (rst),
        .en           (en3),
        .div_ratio    (div_ratio3),
        .div_load     (div_load3),
        .out_clk      (out_clk3),
        .tick         (tick3),
        .phase        (phase3),
        .phase_strobe (phase_strobe3),
        .cur_div      (cur_div3),
        .load_pending (load_pending3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int budget, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!tick && cycles < budget);
        chk("wait_tick", 32'(tick), 1);
    endtask

    initial begin
        int cyc;
        int hi;
        int tot;

        rst = 1'b1; en = 1'b0; div_ratio = '0; div_load = 1'b0;
        en3 = 1'b0; div_ratio3 = '0; div_load3 = 1'b0;
        step(); step();
        chk("rst_out_clk", 32'(out_clk), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_phase", 32'(phase), 1);
        chk("rst_strobe", 32'(phase_strobe), 0);
        chk("rst_cur_div", 32'(cur_div), 2);
        chk("rst_pending", 32'(load_pending), 0);

        // Default divide-by-2 behaviour.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("d2_out_clk", 32'(out_clk), 32'(e_out[i]));
            chk("d2_tick", 32'(tick), 32'(e_tick[i]));
            chk("d2_strobe", 32'(phase_strobe), 32'(e_strb[i]));
        end
        step();
        chk("d2_wrap5_strobe", 32'(phase_strobe), 1);

        // Mid-period load of 5.
        div_load = 1'b1; div_ratio = 8'd5;
        step();
        div_load = 1'b0;
        chk("ld5_pending", 32'(load_pending), 1);
        chk("ld5_cur_old", 32'(cur_div), 2);
        chk("ld5_out_low", 32'(out_clk), 0);
        step();
        chk("ld5_cur_new", 32'(cur_div), 5);
        chk("ld5_pending_clr", 32'(load_pending), 0);
        chk("ld5_tick", 32'(tick), 1);
        chk("ld5_strobe", 32'(phase_strobe), 2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("d5_out_clk", 32'(out_clk), 32'(e_out5[i]));
            chk("d5_tick", 32'(tick), 32'(e_tick5[i]));
        end
        chk("d5_strobe", 32'(phase_strobe), 1);

        // Freeze for 7 cycles during the high phase.
        step();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("hold_out_clk", 32'(out_clk), 1);
            chk("hold_tick", 32'(tick), 0);
            chk("hold_strobe", 32'(phase_strobe), 0);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("resume_out_clk", 32'(out_clk), 32'(e_oresm[i]));
            chk("resume_tick", 32'(tick), 32'(e_tresm[i]));
        end

        // Clamp of 1 and 0 to 2.
        div_load = 1'b1; div_ratio = 8'd1;
        step();
        div_load = 1'b0;
        wait_tick(20, cyc);
        chk("clamp1_cur", 32'(cur_div), 2);
        div_load = 1'b1; div_ratio = 8'd0;
        step();
        div_load = 1'b0;
        chk("clamp0_pending", 32'(load_pending), 1);
        wait_tick(20, cyc);
        chk("clamp0_cur", 32'(cur_div), 2);
        chk("clamp0_pending_clr", 32'(load_pending), 0);

        // Maximum ratio 255: 128 high, 127 low.
        div_load = 1'b1; div_ratio = 8'd255;
        step();
        div_load = 1'b0;
        wait_tick(20, cyc);
        chk("d255_cur", 32'(cur_div), 255);
        hi = 1; tot = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tick) break;
            tot++;
            hi += int'(out_clk);
        end
        chk("d255_period", 32'(tot), 255);
        chk("d255_high", 32'(hi), 128);

        // Back to 2, then loads on consecutive edges, the second on a wrap.
        div_load = 1'b1; div_ratio = 8'd2;
        step();
        div_load = 1'b0;
        wait_tick(300, cyc);
        chk("d2b_cur", 32'(cur_div), 2);
        div_load = 1'b1; div_ratio = 8'd3;
        step();
        div_ratio = 8'd4;
        step();
        div_load = 1'b0;
        chk("wrapld_tick", 32'(tick), 1);
        chk("wrapld_cur", 32'(cur_div), 3);
        chk("wrapld_pending", 32'(load_pending), 1);
        wait_tick(20, cyc);
        chk("wrapld_spacing", 32'(cyc), 3);
        chk("wrapld_cur_last", 32'(cur_div), 4);
        chk("wrapld_pending_clr", 32'(load_pending), 0);

        // Reloading the value in effect still raises pending until the wrap.
        div_load = 1'b1; div_ratio = 8'd4;
        step();
        div_load = 1'b0;
        chk("same_pending", 32'(load_pending), 1);
        wait_tick(20, cyc);
        chk("same_spacing", 32'(cyc), 3);
        chk("same_cur", 32'(cur_div), 4);
        chk("same_pending_clr", 32'(load_pending), 0);

        // Reset mid-period with a pending load.
        div_load = 1'b1; div_ratio = 8'd7;
        step();
        div_load = 1'b0;
        chk("pre_rst_pending", 32'(load_pending), 1);
        rst = 1'b1;
        step();
        chk("mrst_out_clk", 32'(out_clk), 0);
        chk("mrst_tick", 32'(tick), 0);
        chk("mrst_phase", 32'(phase), 1);
        chk("mrst_cur", 32'(cur_div), 2);
        chk("mrst_pending", 32'(load_pending), 0);
        rst = 1'b0;
        step();
        chk("post_rst_tick", 32'(tick), 1);
        chk("post_rst_out_clk", 32'(out_clk), 1);
        chk("post_rst_strobe", 32'(phase_strobe), 1);
        chk("post_rst_cur", 32'(cur_div), 2);
        step(); step();
        chk("post_rst_cur2", 32'(cur_div), 2);

        // Three-phase instance, D=4.
        rst = 1'b1;
        step();
        chk("p3_rst_phase", 32'(phase3), 2);
        rst = 1'b0; en3 = 1'b1;
        step();
        chk("p3_tick0", 32'(tick3), 1);
        chk("p3_strobe0", 32'(phase_strobe3), 32'(e_str3[0]));
        for (int k = 1; k < 4; k++) begin
            step(); step(); step();
            chk("p3_gap_tick", 32'(tick3), 0);
            chk("p3_gap_strobe", 32'(phase_strobe3), 0);
            step();
            chk("p3_tick", 32'(tick3), 1);
            chk("p3_strobe", 32'(phase_strobe3), 32'(e_str3[k]));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_clk_div_phase_gen
`default_nettype wire
